// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 system-control coprocessor.
//   - register addresses, Status/Cause field positions
//   - exception codes, mtc0 write masks and reset values
//   - helpers for write-mask lookup and masked merge
package cp0_pkg;

  typedef logic [4:0] cp0_addr_t;

  localparam cp0_addr_t CP0_REG_BADVADDR = 5'd8;
  localparam cp0_addr_t CP0_REG_COUNT    = 5'd9;
  localparam cp0_addr_t CP0_REG_COMPARE  = 5'd11;
  localparam cp0_addr_t CP0_REG_STATUS   = 5'd12;
  localparam cp0_addr_t CP0_REG_CAUSE    = 5'd13;
  localparam cp0_addr_t CP0_REG_EPC      = 5'd14;
  localparam cp0_addr_t CP0_REG_PRID     = 5'd15;
  localparam cp0_addr_t CP0_REG_CONFIG   = 5'd16;

  // Status fields
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;

  // Cause fields
  localparam int unsigned CAUSE_EXC_LO   = 2;
  localparam int unsigned CAUSE_IP_LO    = 8;
  localparam int unsigned CAUSE_IP_HW_LO = 10;
  localparam int unsigned CAUSE_TI       = 30;
  localparam int unsigned CAUSE_BD       = 31;

  localparam logic [4:0] EXC_CAUSE_INT  = 5'h00;
  localparam logic [4:0] EXC_CAUSE_ADEL = 5'h04;
  localparam logic [4:0] EXC_CAUSE_ADES = 5'h05;
  localparam logic [4:0] EXC_CAUSE_NOP  = 5'h1F;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_FF00;

  // Zero mask means the address is not writable by mtc0.
  function automatic logic [31:0] cp0_wmask(input cp0_addr_t addr);
    logic [31:0] m;
    case (addr)
      CP0_REG_COUNT, CP0_REG_COMPARE, CP0_REG_EPC: m = '1;
      CP0_REG_STATUS:                              m = STATUS_WMASK;
      CP0_REG_CAUSE:                               m = CAUSE_WMASK;
      default:                                     m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] cp0_merge(input logic [31:0] cur,
                                            input logic [31:0] wdata,
                                            input logic [31:0] mask);
    return (wdata & mask) | (cur & ~mask);
  endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// cp0_count_timer: Count/Compare pair with prescaler and timer interrupt.
//   clk, reset        : clock, async active-high reset
//   count_we/_wdata   : mtc0 to Count (loads Count, restarts prescaler)
//   compare_we/_wdata : mtc0 to Compare (also clears timer_int)
//   count, compare    : current register values
//   timer_int         : Cause.TI
module cp0_count_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (presc == PW'(COUNT_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      count <= '0;
    end else if (count_we) begin
      count <= count_wdata;
      presc <= '0;
    end else if (wrap) begin
      count <= count + 32'd1;
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare <= '0;
    end else if (compare_we) begin
      compare <= compare_wdata;
    end
  end

  // A Compare write clears TI even when a match lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_int <= 1'b0;
    end else if (compare_we) begin
      timer_int <= 1'b0;
    end else if (wrap && (count == compare)) begin
      timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_param.sv
// cp0_param: parametrised CP0 system-control coprocessor.
//   mtc0 port (i_we/i_waddr/i_wdata), mfc0 port (i_raddr/o_rdata, write bypass),
//   commit inputs (i_except_cause, i_current_pc, i_is_in_delay_slot, i_is_eret),
//   level interrupts i_int, register outputs, o_take_exc (combinational), o_timer_int.
//   Optional: define CP0_BADVADDR_EN to implement BadVAddr (reg 8).
module cp0_param
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [4:0]            i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [4:0]            i_raddr,
  output logic [31:0]           o_rdata,
  input  logic [4:0]            i_except_cause,
  input  logic [NUM_HW_INT-1:0] i_int,
  input  logic [31:0]           i_current_pc,
  input  logic                  i_is_in_delay_slot,
  input  logic                  i_is_eret,
  input  logic [31:0]           i_bad_vaddr,
  output logic [31:0]           o_status_reg,
  output logic [31:0]           o_cause_reg,
  output logic [31:0]           o_epc_reg,
  output logic                  o_take_exc,
  output logic                  o_timer_int
);

  logic [31:0] status_q, status_d, epc_q, cause_val;
  logic        cause_bd_q;
  logic [4:0]  cause_exc_q;
  logic [1:0]  cause_ip_sw_q;
  logic [5:0]  cause_ip_hw_q, int_pad, ip_hw_next;
  logic [31:0] count, compare, rdata_reg;
  logic        timer_int, int_req, take, exc_pending;
  logic [4:0]  commit_code;
  logic        wr_status, wr_cause, wr_epc;

  assign wr_status = i_we && (i_waddr == CP0_REG_STATUS);
  assign wr_cause  = i_we && (i_waddr == CP0_REG_CAUSE);
  assign wr_epc    = i_we && (i_waddr == CP0_REG_EPC);

  cp0_count_timer #(.COUNT_DIV(COUNT_DIV)) u_count_timer (
    .clk           (clk),
    .reset         (reset),
    .count_we      (i_we && (i_waddr == CP0_REG_COUNT)),
    .count_wdata   (i_wdata),
    .compare_we    (i_we && (i_waddr == CP0_REG_COMPARE)),
    .compare_wdata (i_wdata),
    .count         (count),
    .compare       (compare),
    .timer_int     (timer_int)
  );

  assign cause_val = {cause_bd_q, timer_int, 14'b0, cause_ip_hw_q, cause_ip_sw_q,
                      1'b0, cause_exc_q, 2'b00};

  assign int_req = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                 & |(cause_val[CAUSE_IP_LO +: 8] & status_q[STATUS_IM_LO +: 8]);
  assign exc_pending = (i_except_cause != EXC_CAUSE_NOP);
  assign take        = ~i_is_eret & (int_req | (~status_q[STATUS_EXL] & exc_pending));
  assign commit_code = int_req ? EXC_CAUSE_INT : i_except_cause;

  // Unused interrupt lines read as 0; TI is folded into IP[7].
  always_comb begin
    int_pad = '0;
    int_pad[NUM_HW_INT-1:0] = i_int;
    ip_hw_next = int_pad | {timer_int, 5'b0};
  end

  // EXL from commit/eret overrides the mtc0 value in the same cycle.
  always_comb begin
    status_d = status_q;
    if (wr_status) status_d = cp0_merge(status_q, i_wdata, STATUS_WMASK);
    if (take)           status_d[STATUS_EXL] = 1'b1;
    else if (i_is_eret) status_d[STATUS_EXL] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q      <= STATUS_RESET;
      epc_q         <= '0;
      cause_bd_q    <= 1'b0;
      cause_exc_q   <= '0;
      cause_ip_sw_q <= '0;
      cause_ip_hw_q <= '0;
    end else begin
      status_q      <= status_d;
      cause_ip_hw_q <= ip_hw_next;
      if (wr_cause) cause_ip_sw_q <= i_wdata[9:8];
      if (take) begin
        epc_q       <= i_current_pc - (i_is_in_delay_slot ? 32'd4 : 32'd0);
        cause_bd_q  <= i_is_in_delay_slot;
        cause_exc_q <= commit_code;
      end else if (wr_epc) begin
        epc_q <= i_wdata;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_q <= '0;
    end else if (take && ((commit_code == EXC_CAUSE_ADEL) || (commit_code == EXC_CAUSE_ADES))) begin
      badvaddr_q <= i_bad_vaddr;
    end
  end
`else
  logic unused_bad_vaddr;
  assign unused_bad_vaddr = ^i_bad_vaddr;
`endif

  always_comb begin
    case (i_raddr)
`ifdef CP0_BADVADDR_EN
      CP0_REG_BADVADDR: rdata_reg = badvaddr_q;
`endif
      CP0_REG_COUNT:   rdata_reg = count;
      CP0_REG_COMPARE: rdata_reg = compare;
      CP0_REG_STATUS:  rdata_reg = status_q;
      CP0_REG_CAUSE:   rdata_reg = cause_val;
      CP0_REG_EPC:     rdata_reg = epc_q;
      CP0_REG_PRID:    rdata_reg = PRID_VAL;
      CP0_REG_CONFIG:  rdata_reg = CONFIG_VAL;
      default:         rdata_reg = '0;
    endcase
    // Read-only addresses have a zero mask, so the merge leaves them unchanged.
    o_rdata = rdata_reg;
    if (i_we && (i_waddr == i_raddr))
      o_rdata = cp0_merge(rdata_reg, i_wdata, cp0_wmask(i_raddr));
  end

  assign o_status_reg = status_q;
  assign o_cause_reg  = cause_val;
  assign o_epc_reg    = epc_q;
  assign o_take_exc   = take;
  assign o_timer_int  = timer_int;

endmodule

// File: doc/cp0_param.md
Name: cp0_param

Overview:
- Parametrised successor of the CP0 system-control coprocessor, instantiated next to the EX/MEM stage.
- Holds Count/Compare/Status/Cause/EPC/PrId/Config and an optional BadVAddr register.
- Adds configurable interrupt-line count, a Count prescaler, a proper IE/EXL/IM interrupt gate and a defined same-cycle priority between eret, exception commit and mtc0.
- Produces the take-exception decision consumed by the PC/flush logic.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt inputs (1..6), mapped to Cause.IP[2+k]; unused IP bits read 0.
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1..16).
- PRID_VAL, 32'h00480102, constant read from PrId.
- CONFIG_VAL, 32'h00008000, constant read from Config.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_we  in  1  mtc0 write enable
- i_waddr  in  5  mtc0 register address
- i_wdata  in  32  mtc0 data
- i_raddr  in  5  mfc0 register address
- o_rdata  out  32  mfc0 data, with write bypass
- i_except_cause  in  5  exception code of the committing instruction; EXC_CAUSE_NOP means none
- i_int  in  NUM_HW_INT  level hardware interrupts, already synchronous
- i_current_pc  in  32  PC of the committing instruction
- i_is_in_delay_slot  in  1  committing instruction is in a delay slot
- i_is_eret  in  1  eret commits this cycle
- i_bad_vaddr  in  32  faulting address (used only with CP0_BADVADDR_EN)
- o_status_reg  out  32  Status register
- o_cause_reg  out  32  Cause register
- o_epc_reg  out  32  EPC register
- o_take_exc  out  1  combinational: exception or interrupt is taken this cycle
- o_timer_int  out  1  Cause.TI

Behaviour:
- Reset values (asynchronous):
  - Count=0, Compare=0, Status=32'h0040FF00 (IM all set, EXL=0, IE=0), Cause=0, EPC=0, BadVAddr=0.
  - Prescaler=0, o_timer_int=0.
  - PrId and Config are constants, never written.
- Register map: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PrId 15, Config 16. All other addresses read 0; writes to them are ignored.
- Write masks:
  - Status: writable bits 15:8, 1, 0 only.
  - Cause: writable bits 9:8 (software interrupts) only.
  - Count, Compare, EPC: full 32-bit writes.
  - PrId, Config, BadVAddr: read-only.
- Read bypass: if i_we and i_waddr==i_raddr and the address is writable, o_rdata = the masked merge of i_wdata with the current value; otherwise o_rdata = the register value.
- Count:
  - The prescaler counts 0..COUNT_DIV-1; Count += 1 (mod 2^32) on the cycle the prescaler wraps.
  - An mtc0 to Count loads i_wdata and resets the prescaler to 0; the write wins over the increment.
- Timer interrupt:
  - Cause.TI (bit 30) is set on the cycle Count==Compare and the prescaler wraps.
  - TI is cleared by any mtc0 to Compare; if the clear and the set fall in the same cycle, the clear wins.
  - TI is ORed into IP[7].
- Cause.IP[7:2] is refreshed every cycle from i_int (plus TI on IP[7]), with a 1-cycle register latency.
- Interrupt request: int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- o_take_exc = ~i_is_eret & (int_req | (~Status.EXL & i_except_cause != EXC_CAUSE_NOP)).
- Commit, when o_take_exc is high, at the next edge:
  - EPC = i_current_pc - (i_is_in_delay_slot ? 4 : 0).
  - Cause.BD = i_is_in_delay_slot.
  - Cause.ExcCode = EXC_CAUSE_INT if int_req, else i_except_cause; the interrupt has priority.
  - Status.EXL = 1.
- eret: Status.EXL=0. No exception is taken that cycle.
- While EXL=1, synchronous exceptions and interrupts are not taken: no EPC or Cause update.
- Same-cycle priority for Status/Cause/EPC fields: commit or eret > mtc0 > hardware refresh.

Optional Feature:
- CP0_BADVADDR_EN defined:
  - BadVAddr (reg 8) loads i_bad_vaddr on a taken exception with ExcCode AdEL (4) or AdES (5).
  - Otherwise BadVAddr holds its value.
- Not defined:
  - The register is absent and reads 0.
  - i_bad_vaddr is ignored.

Decomposition:
- Package cp0_pkg holds:
  - Register address constants.
  - Status/Cause field bit positions.
  - EXC_CAUSE_* codes: INT=5'h00, ADEL=5'h04, ADES=5'h05, NOP=5'h1F.
  - Write masks.
- One sub-module, cp0_count_timer, holds the prescaler, Count, Compare and TI. Its ports are the Count/Compare write strobes and data, with Count, Compare and timer_int as outputs.

Test Plan:
- Reset → rdata(12)=32'h0040FF00, rdata(15)=PRID_VAL, o_take_exc=0; reset asserted mid-count → Count=0 immediately.
- COUNT_DIV=2, write Compare=5 → o_timer_int rises after Count reaches 5 (about 10 clocks after reset); a later mtc0 Compare clears it.
- Status=32'h0000FC01, i_int[0]=1 → o_take_exc=1 one cycle later. Commit with pc=32'h100, BD=1 → EPC=32'hFC, ExcCode=0, EXL=1; a further int is ignored until eret.
- Sync cause 5'h0C with EXL=0 → EPC=pc, ExcCode=12; same cycle with int_req=1 → ExcCode=0.
- mtc0 Count=7 at the prescaler wrap → Count=7, not 8; same-cycle mfc0 Count returns 7 via bypass.
- CP0_BADVADDR_EN, cause AdEL, i_bad_vaddr=32'hDEAD0003 → rdata(8)=32'hDEAD0003; without the macro → 0.
